// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared 8-bit adder/subtractor.
// Requests are accepted only in IDLE; each result is held until the consumer takes it.

module eight_bit_adder_subtractor (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       op,
  output logic [7:0] sum,
  output logic       carry_out,
  output logic       overflow
);
  logic [7:0] y_eff;
  logic       carry_7;

  // Subtract is x + ~y + 1; the carry into bit 7 is kept for the overflow term.
  assign y_eff = op ? ~y : y;
  assign {carry_7, sum[6:0]}   = {1'b0, x[6:0]} + {1'b0, y_eff[6:0]} + {7'b0, op};
  assign {carry_out, sum[7]}   = {1'b0, x[7]} + {1'b0, y_eff[7]} + {1'b0, carry_7};
  assign overflow              = carry_7 ^ carry_out;
endmodule

module addsub_arbiter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic       req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  input  logic       req1_op,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_sum,
  output logic       resp_carry,
  output logic       resp_overflow
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic       grant0, grant1;
  logic [7:0] opr_x, opr_y;
  logic       opr_op, opr_id;
  logic [7:0] alu_sum;
  logic       alu_carry, alu_overflow;
  logic       accept0, accept1;

  eight_bit_adder_subtractor u_alu (
    .x         (opr_x),
    .y         (opr_y),
    .op        (opr_op),
    .sum       (alu_sum),
    .carry_out (alu_carry),
    .overflow  (alu_overflow)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_next = state;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    // Readies are forced low while reset is held, even though state reads IDLE.
    req0_ready = rstn && (state == IDLE) && grant0;
    req1_ready = rstn && (state == IDLE) && grant1;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: all datapath registers have an async reset, so an in-flight result vanishes on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant    <= 1'b1;
      opr_x         <= 8'h00;
      opr_y         <= 8'h00;
      opr_op        <= 1'b0;
      opr_id        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_sum      <= 8'h00;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            opr_x      <= req0_x;
            opr_y      <= req0_y;
            opr_op     <= req0_op;
            opr_id     <= 1'b0;
            last_grant <= 1'b0;
          end else if (accept1) begin
            opr_x      <= req1_x;
            opr_y      <= req1_y;
            opr_op     <= req1_op;
            opr_id     <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        EXEC: begin
          resp_valid    <= 1'b1;
          resp_id       <= opr_id;
          resp_sum      <= alu_sum;
          resp_carry    <= alu_carry;
          resp_overflow <= alu_overflow;
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: transaction-level reference model with a
// per-cycle compare, plus directed cases with hand-computed expectations.

module tb_addsub_arbiter;
  logic       clk, rstn;
  logic       req0_valid, req0_ready, req0_op;
  logic [7:0] req0_x, req0_y;
  logic       req1_valid, req1_ready, req1_op;
  logic [7:0] req1_x, req1_y;
  logic       resp_valid, resp_ready, resp_id, resp_carry, resp_overflow;
  logic [7:0] resp_sum;

  int n_checks = 0;
  int n_errors = 0;

  addsub_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_carry(resp_carry), .resp_overflow(resp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic       id;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    int         vis;   // edge count from which the result is visible
  } exp_t;

  exp_t q[$];
  int   edges;
  logic m_last;
  exp_t e;
  logic g;

  function automatic exp_t compute(input logic id, input logic [7:0] x, input logic [7:0] y, input logic op);
    exp_t r;
    int a, b, s, sa, sb, ss;
    a  = x;  b  = y;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    if (op) begin s = a - b; r.carry = (a >= b);  ss = sa - sb; end
    else    begin s = a + b; r.carry = (s > 255); ss = sa + sb; end
    r.sum = 8'(s & 255);
    r.ovf = (ss < -128) || (ss > 127);
    r.id  = id;
    r.vis = 0;
    return r;
  endfunction

  // Which requester the rules pick right now (only meaningful if one is valid).
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_last = 1'b1;
      edges  = 0;
    end else begin
      if (q.size() > 0 && edges >= q[0].vis && resp_ready) begin
        void'(q.pop_front());
      end else if (q.size() == 0 && (req0_valid || req1_valid)) begin
        g = pick(req0_valid, req1_valid, m_last);
        e = g ? compute(1'b1, req1_x, req1_y, req1_op) : compute(1'b0, req0_x, req0_y, req0_op);
        e.vis = edges + 2;
        q.push_back(e);
        m_last = g;
      end
      edges++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_r0, exp_r1, exp_v;
    exp_r0 = 1'b0; exp_r1 = 1'b0; exp_v = 1'b0;
    if (rstn && q.size() == 0 && (req0_valid || req1_valid)) begin
      exp_r0 = !pick(req0_valid, req1_valid, m_last);
      exp_r1 =  pick(req0_valid, req1_valid, m_last);
    end
    if (rstn && q.size() > 0 && edges >= q[0].vis) exp_v = 1'b1;
    check("cyc_req0_ready", req0_ready, exp_r0);
    check("cyc_req1_ready", req1_ready, exp_r1);
    check("cyc_resp_valid", resp_valid, exp_v);
    if (exp_v) begin
      check("cyc_resp_id",  resp_id,       q[0].id);
      check("cyc_resp_sum", resp_sum,      q[0].sum);
      check("cyc_carry",    resp_carry,    q[0].carry);
      check("cyc_overflow", resp_overflow, q[0].ovf);
    end
    if (!rstn) begin
      check("cyc_rst_sum", {resp_id, resp_carry, resp_overflow, resp_sum}, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [7:0] x, input logic [7:0] y, input logic op);
    if (id) begin req1_valid = v; req1_x = x; req1_y = y; req1_op = op; end
    else    begin req0_valid = v; req0_x = x; req0_y = y; req0_op = op; end
  endtask

  function automatic logic ready_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic do_op(input string name, input logic id, input logic [7:0] x, input logic [7:0] y,
                       input logic op, input logic [7:0] es, input logic ec, input logic eo);
    int n, lat;
    drive(id, 1'b1, x, y, op);
    #1;
    n = 0;
    while (!ready_of(id) && n < 20) begin step(); #1; n++; end
    if (n >= 20) check({name, "_ready_timeout"}, 0, 1);
    step();
    drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    #1;
    while (!resp_valid && lat < 20) begin step(); #1; lat++; end
    check({name, "_latency"},  lat, 2);
    check({name, "_id"},       resp_id, id);
    check({name, "_sum"},      resp_sum, es);
    check({name, "_carry"},    resp_carry, ec);
    check({name, "_overflow"}, resp_overflow, eo);
    step();
  endtask

  initial begin
    logic ids[$];
    rstn = 1'b0; resp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
    drive(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_resp",   {resp_valid, resp_id, resp_carry, resp_overflow, resp_sum}, 0);
    step(); step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    rstn = 1'b1;
    step();

    do_op("add",      1'b0, 8'h64, 8'h32, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op("sub_brw",  1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_ok",   1'b1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    do_op("wrap",     1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("sub_ovf",  1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: result 3+4 held for five cycles while both requesters wait.
    resp_ready = 1'b0;
    drive(1'b0, 1'b1, 8'h03, 8'h04, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
    drive(1'b1, 1'b1, 8'h30, 8'h40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid",  resp_valid, 1);
      check("bp_sum",    {resp_id, resp_carry, resp_overflow, resp_sum}, 11'h007);
      check("bp_readies", {req0_ready, req1_ready}, 2'b00);
      step();
    end
    resp_ready = 1'b1;
    step();
    #1;
    check("bp_done_valid", resp_valid, 0);
    check("bp_idle_grant", {req0_ready, req1_ready}, 2'b01);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step();

    // Reset while a result is pending in RESP.
    resp_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h09, 8'h01, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(); step();
    check("pre_rst_valid", resp_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_resp",  {resp_id, resp_carry, resp_overflow, resp_sum}, 0);
    resp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    drive(1'b1, 1'b1, 8'h03, 8'h04, 1'b1);
    step();
    rstn = 1'b1;
    #1;
    check("post_rst_first_tie", {req0_ready, req1_ready}, 2'b10);

    // Contention with changing operands: grants must alternate from requester 0.
    for (int i = 0; i < 16; i++) begin
      step();
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      #1;
      if (resp_valid) ids.push_back(resp_id);
    end
    check("cont_count", (ids.size() >= 4), 1);
    if (ids.size() >= 4) check("cont_order", {ids[0], ids[1], ids[2], ids[3]}, 4'b0101);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      drive(1'b0, 1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1'b1, 1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      resp_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rstn = 1'b0;
        #4 rstn = 1'b1;
      end
    end
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
